// File: rtl/dma_controller_pkg.sv
// Shared encodings and helpers for the DMA controller: item sizes, channel
// engine state set, and size-derived address step / data mask.
package dma_controller_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_REQ,
        ST_READ,
        ST_WRITE,
        ST_HALT
    } dma_state_t;

    function automatic logic [2:0] size_to_inc(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 32'h0000_00ff;
            SIZE_HALF: return 32'h0000_ffff;
            default:   return 32'hffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/dma_flag_unit.sv
// Channel status flags (TC/HT/TE) with set-over-clear priority, global flag
// and enable-gated interrupt line.
module dma_flag_unit (
    input  logic clk,
    input  logic rst,
    input  logic set_tc,
    input  logic set_ht,
    input  logic set_te,
    input  logic clear_gif,
    input  logic clear_tcif,
    input  logic clear_htif,
    input  logic clear_teif,
    input  logic tci_irq_en,
    input  logic hti_irq_en,
    input  logic tei_irq_en,
    output logic tcif,
    output logic htif,
    output logic teif,
    output logic gif,
    output logic irq
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcif <= 1'b0;
            htif <= 1'b0;
            teif <= 1'b0;
        end else begin
            tcif <= set_tc | (tcif & ~(clear_tcif | clear_gif));
            htif <= set_ht | (htif & ~(clear_htif | clear_gif));
            teif <= set_te | (teif & ~(clear_teif | clear_gif));
        end
    end

    assign gif = tcif | htif | teif;
    assign irq = (tcif & tci_irq_en) | (htif & hti_irq_en) | (teif & tei_irq_en);

endmodule

// File: rtl/dma_channel_engine.sv
// Single DMA channel: runs read-then-write item transfers on a req/ack master
// port, tracks addresses and item count, and reports TC/HT/TE status.
module dma_channel_engine
    import dma_controller_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              channel_en,
    input  logic              tci_irq_en,
    input  logic              hti_irq_en,
    input  logic              tei_irq_en,
    input  logic              direction,
    input  logic              circular_mode,
    input  logic              periph_addr_inc_en,
    input  logic              mem_addr_inc_en,
    input  logic              mem2mem_mode_en,
    input  logic [1:0]        periph_addr_size,
    input  logic [1:0]        mem_addr_size,
    input  logic [CNT_W-1:0]  data_byte_cnt,
    input  logic [ADDR_W-1:0] periph_copy_address,
    input  logic [ADDR_W-1:0] mem_copy_address,
    input  logic              clear_gif,
    input  logic              clear_tcif,
    input  logic              clear_htif,
    input  logic              clear_teif,
    output logic              gif_irq,
    output logic              tcif_irq,
    output logic              htif_irq,
    output logic              teif_irq,
    output logic              irq,
    input  logic              periph_dreq,
    output logic              periph_dack,
    output logic              rd_req,
    output logic              wr_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        rd_size,
    output logic [1:0]        wr_size,
    input  logic              rd_ack,
    input  logic              wr_ack,
    input  logic              rd_err,
    input  logic              wr_err,
    input  logic [31:0]       rd_data,
    output logic [31:0]       wr_data,
    output logic [CNT_W-1:0]  remaining_cnt,
    output logic              busy
);

    dma_state_t state, state_next;

    logic              en_q;
    logic              item_done;
    logic [ADDR_W-1:0] periph_addr, mem_addr;
    logic [ADDR_W-1:0] periph_base, mem_base;
    logic [CNT_W-1:0]  latched_cnt;
    logic [31:0]       data_q;

    logic              en_rise, start_bad;
    logic              rd_done, wr_done, wr_good;
    logic [CNT_W-1:0]  cnt_dec;
    logic              last_item;
    logic              set_tc, set_ht, set_te;
    logic [1:0]        src_size, dst_size;
    logic [ADDR_W-1:0] periph_step, mem_step;

    assign src_size = direction ? mem_addr_size : periph_addr_size;
    assign dst_size = direction ? periph_addr_size : mem_addr_size;
    assign rd_addr  = direction ? mem_addr : periph_addr;
    assign wr_addr  = direction ? periph_addr : mem_addr;
    assign rd_size  = src_size;
    assign wr_size  = dst_size;

    assign periph_step = ADDR_W'(size_to_inc(periph_addr_size));
    assign mem_step    = ADDR_W'(size_to_inc(mem_addr_size));

    assign en_rise   = channel_en & ~en_q;
    assign start_bad = (data_byte_cnt == '0) ||
                       (periph_addr_size == SIZE_RSVD) ||
                       (mem_addr_size == SIZE_RSVD);

    assign rd_done   = (state == ST_READ) && rd_ack;
    assign wr_done   = (state == ST_WRITE) && wr_ack;
    assign wr_good   = wr_done && !wr_err;
    assign cnt_dec   = remaining_cnt - CNT_W'(1);
    assign last_item = (cnt_dec == '0);

    assign set_tc = wr_good && last_item;
    assign set_ht = wr_good && (latched_cnt >= CNT_W'(2)) && (cnt_dec == (latched_cnt >> 1));
    assign set_te = ((state == ST_IDLE) && en_rise && start_bad) ||
                    (rd_done && rd_err) || (wr_done && wr_err);

    assign rd_req  = (state == ST_READ);
    assign wr_req  = (state == ST_WRITE);
    assign busy    = (state != ST_IDLE) && (state != ST_HALT);
    assign wr_data = data_q & size_mask(dst_size);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // item_done holds WAIT_REQ for one cycle after each item, giving the
    // peripheral the dack cycle to drop dreq before it is sampled again.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (en_rise) begin
                    state_next = start_bad ? ST_HALT : ST_WAIT_REQ;
                end
            end
            ST_WAIT_REQ: begin
                if (!channel_en) begin
                    state_next = ST_IDLE;
                end else if (!item_done && (mem2mem_mode_en || periph_dreq)) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (rd_ack) begin
                    state_next = rd_err ? ST_HALT : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_ack) begin
                    if (wr_err) begin
                        state_next = ST_HALT;
                    end else if (!channel_en || (last_item && !circular_mode)) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_WAIT_REQ;
                    end
                end
            end
            ST_HALT: begin
                if (!channel_en) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q          <= 1'b0;
            item_done     <= 1'b0;
            periph_dack   <= 1'b0;
            periph_addr   <= '0;
            mem_addr      <= '0;
            periph_base   <= '0;
            mem_base      <= '0;
            latched_cnt   <= '0;
            remaining_cnt <= '0;
            data_q        <= '0;
        end else begin
            en_q        <= channel_en;
            item_done   <= wr_good;
            periph_dack <= wr_good && !mem2mem_mode_en;

            if ((state == ST_IDLE) && en_rise) begin
                periph_base   <= periph_copy_address;
                mem_base      <= mem_copy_address;
                periph_addr   <= periph_copy_address;
                mem_addr      <= mem_copy_address;
                latched_cnt   <= data_byte_cnt;
                remaining_cnt <= data_byte_cnt;
            end

            // Source bits beyond the source size are dropped at capture so a
            // narrow read lands zero-extended in a wider write.
            if (rd_done && !rd_err) begin
                data_q <= rd_data & size_mask(src_size);
            end

            if (wr_good) begin
                if (last_item && circular_mode) begin
                    remaining_cnt <= latched_cnt;
                    periph_addr   <= periph_base;
                    mem_addr      <= mem_base;
                end else begin
                    remaining_cnt <= cnt_dec;
                    if (periph_addr_inc_en) begin
                        periph_addr <= periph_addr + periph_step;
                    end
                    if (mem_addr_inc_en) begin
                        mem_addr <= mem_addr + mem_step;
                    end
                end
            end
        end
    end

    dma_flag_unit u_flags (
        .clk        (clk),
        .rst        (rst),
        .set_tc     (set_tc),
        .set_ht     (set_ht),
        .set_te     (set_te),
        .clear_gif  (clear_gif),
        .clear_tcif (clear_tcif),
        .clear_htif (clear_htif),
        .clear_teif (clear_teif),
        .tci_irq_en (tci_irq_en),
        .hti_irq_en (hti_irq_en),
        .tei_irq_en (tei_irq_en),
        .tcif       (tcif_irq),
        .htif       (htif_irq),
        .teif       (teif_irq),
        .gif        (gif_irq),
        .irq        (irq)
    );

endmodule

// File: tb/tb_dma_channel_engine.sv
// Directed bench for dma_channel_engine: a bus responder serves reads/writes,
// a monitor checks each beat against queued expectations.
module tb_dma_channel_engine;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        channel_en = 0, tci_irq_en = 0, hti_irq_en = 0, tei_irq_en = 0;
    logic        direction = 0, circular_mode = 0, periph_addr_inc_en = 0;
    logic        mem_addr_inc_en = 0, mem2mem_mode_en = 0;
    logic [1:0]  periph_addr_size = 0, mem_addr_size = 0;
    logic [15:0] data_byte_cnt = 0;
    logic [31:0] periph_copy_address = 0, mem_copy_address = 0;
    logic        clear_gif = 0, clear_tcif = 0, clear_htif = 0, clear_teif = 0;
    logic        gif_irq, tcif_irq, htif_irq, teif_irq, irq;
    logic        periph_dreq = 0, periph_dack;
    logic        rd_req, wr_req;
    logic [31:0] rd_addr, wr_addr;
    logic [1:0]  rd_size, wr_size;
    logic        rd_ack = 0, wr_ack = 0, rd_err = 0, wr_err = 0;
    logic [31:0] rd_data = 0, wr_data;
    logic [15:0] remaining_cnt;
    logic        busy;

    int compared = 0;
    int failed   = 0;
    int rd_cnt = 0, wr_cnt = 0, dack_cnt = 0;
    int rd_err_at = -1;
    logic wr_hold = 1'b0;
    int base, dbase;

    beat_t       exp_rd_q[$];
    beat_t       exp_wr_q[$];
    logic [31:0] rd_data_q[$];

    dma_channel_engine #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .channel_en(channel_en),
        .tci_irq_en(tci_irq_en), .hti_irq_en(hti_irq_en), .tei_irq_en(tei_irq_en),
        .direction(direction), .circular_mode(circular_mode),
        .periph_addr_inc_en(periph_addr_inc_en), .mem_addr_inc_en(mem_addr_inc_en),
        .mem2mem_mode_en(mem2mem_mode_en),
        .periph_addr_size(periph_addr_size), .mem_addr_size(mem_addr_size),
        .data_byte_cnt(data_byte_cnt),
        .periph_copy_address(periph_copy_address), .mem_copy_address(mem_copy_address),
        .clear_gif(clear_gif), .clear_tcif(clear_tcif), .clear_htif(clear_htif),
        .clear_teif(clear_teif),
        .gif_irq(gif_irq), .tcif_irq(tcif_irq), .htif_irq(htif_irq), .teif_irq(teif_irq),
        .irq(irq), .periph_dreq(periph_dreq), .periph_dack(periph_dack),
        .rd_req(rd_req), .wr_req(wr_req), .rd_addr(rd_addr), .wr_addr(wr_addr),
        .rd_size(rd_size), .wr_size(wr_size), .rd_ack(rd_ack), .wr_ack(wr_ack),
        .rd_err(rd_err), .wr_err(wr_err), .rd_data(rd_data), .wr_data(wr_data),
        .remaining_cnt(remaining_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bus slave: zero-wait acks driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        rd_ack  = rd_req;
        rd_err  = rd_req && (rd_cnt == rd_err_at);
        rd_data = (rd_data_q.size() > 0) ? rd_data_q[0] : 32'h0;
        wr_ack  = wr_req && !wr_hold;
        wr_err  = 1'b0;
    end

    // Monitor: every accepted beat is checked against the scoreboard.
    always @(negedge clk) begin
        beat_t       e;
        logic [31:0] junk;
        if (rst) begin
            if (rd_req && rd_ack) begin
                compared++;
                if (exp_rd_q.size() == 0) begin
                    failed++;
                    $display("FAIL rd_beat: unexpected read addr=%h size=%0d, required none", rd_addr, rd_size);
                end else begin
                    e = exp_rd_q.pop_front();
                    if (rd_addr !== e.addr || rd_size !== e.size) begin
                        failed++;
                        $display("FAIL rd_beat: got addr=%h size=%0d, required addr=%h size=%0d",
                                 rd_addr, rd_size, e.addr, e.size);
                    end
                end
                if (rd_data_q.size() > 0) junk = rd_data_q.pop_front();
                rd_cnt++;
            end
            if (wr_req && wr_ack) begin
                compared++;
                if (exp_wr_q.size() == 0) begin
                    failed++;
                    $display("FAIL wr_beat: unexpected write addr=%h data=%h, required none", wr_addr, wr_data);
                end else begin
                    e = exp_wr_q.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data || wr_size !== e.size) begin
                        failed++;
                        $display("FAIL wr_beat: got addr=%h data=%h size=%0d, required addr=%h data=%h size=%0d",
                                 wr_addr, wr_data, wr_size, e.addr, e.data, e.size);
                    end
                end
                wr_cnt++;
            end
            if (periph_dack) dack_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        compared++;
        failed++;
        $display("FAIL %s: timed out waiting, required event did not occur", name);
    endtask

    task automatic push_rd(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        beat_t b;
        b.addr = a; b.size = s; b.data = d;
        exp_rd_q.push_back(b);
        rd_data_q.push_back(d);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        beat_t b;
        b.addr = a; b.size = s; b.data = d;
        exp_wr_q.push_back(b);
    endtask

    task automatic wait_wr(input int target);
        for (int c = 0; c < 300; c++) begin
            if (wr_cnt >= target) return;
            tick();
        end
        timeout("wait_wr");
    endtask

    task automatic wait_wreq(input int target);
        for (int c = 0; c < 300; c++) begin
            if (wr_cnt == target && wr_req) return;
            tick();
        end
        timeout("wait_wreq");
    endtask

    task automatic cleanup();
        channel_en = 1'b0;
        tick();
        clear_gif = 1'b1;
        tick();
        clear_gif = 1'b0;
        tick();
    endtask

    task automatic cfg(input logic dir, input logic m2m, input logic [1:0] psz, input logic [1:0] msz,
                       input logic pinc, input logic minc, input logic circ, input logic [15:0] n,
                       input logic [31:0] pa, input logic [31:0] ma);
        direction = dir; mem2mem_mode_en = m2m; periph_addr_size = psz; mem_addr_size = msz;
        periph_addr_inc_en = pinc; mem_addr_inc_en = minc; circular_mode = circ;
        data_byte_cnt = n; periph_copy_address = pa; mem_copy_address = ma;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        tick();

        check("rst_flags", {27'd0, gif_irq, tcif_irq, htif_irq, teif_irq, irq}, 32'h0);
        check("rst_reqs", {28'd0, periph_dack, rd_req, wr_req, busy}, 32'h0);
        check("rst_rd_addr", rd_addr, 32'h0);
        check("rst_wr_addr", wr_addr, 32'h0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_cnt", 32'(remaining_cnt), 32'h0);

        // mem2mem, mem->periph word/word, N=4, both increments.
        cfg(1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 16'd4, 32'h2000, 32'h1000);
        tci_irq_en = 1; hti_irq_en = 0; tei_irq_en = 1;
        push_rd(32'h1000, 2'b10, 32'h1111_0001); push_wr(32'h2000, 2'b10, 32'h1111_0001);
        push_rd(32'h1004, 2'b10, 32'h2222_0002); push_wr(32'h2004, 2'b10, 32'h2222_0002);
        push_rd(32'h1008, 2'b10, 32'h3333_0003); push_wr(32'h2008, 2'b10, 32'h3333_0003);
        push_rd(32'h100C, 2'b10, 32'h4444_0004); push_wr(32'h200C, 2'b10, 32'h4444_0004);
        base = wr_cnt; dbase = dack_cnt;
        channel_en = 1'b1;
        tick();
        check("t1_lat_rd_c1", {31'd0, rd_req}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        tick();
        check("t1_lat_rd_c2", {31'd0, rd_req}, 32'd1);
        tick();
        check("t1_lat_wr", {31'd0, wr_req}, 32'd1);
        wait_wr(base + 2);
        check("t1_ht_htif", {31'd0, htif_irq}, 32'd1);
        check("t1_ht_tcif", {31'd0, tcif_irq}, 32'd0);
        check("t1_ht_irq", {31'd0, irq}, 32'd0);
        check("t1_ht_cnt", 32'(remaining_cnt), 32'd2);
        wait_wr(base + 4);
        check("t1_tc_tcif", {31'd0, tcif_irq}, 32'd1);
        check("t1_tc_gif", {31'd0, gif_irq}, 32'd1);
        check("t1_tc_irq", {31'd0, irq}, 32'd1);
        check("t1_tc_cnt", 32'(remaining_cnt), 32'd0);
        check("t1_idle", {31'd0, busy}, 32'd0);
        check("t1_no_dack", 32'(dack_cnt - dbase), 32'd0);
        tci_irq_en = 0; hti_irq_en = 1;
        #1 check("t1_irq_ht_en", {31'd0, irq}, 32'd1);
        hti_irq_en = 0;
        #1 check("t1_irq_off", {31'd0, irq}, 32'd0);
        cleanup();
        check("t1_clear_gif", {28'd0, gif_irq, tcif_irq, htif_irq, teif_irq}, 32'h0);

        // periph->mem byte->word, fixed periph address, dreq per item.
        cfg(1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 16'd3, 32'h0040, 32'h3000);
        tci_irq_en = 1;
        push_rd(32'h0040, 2'b00, 32'hAABB_CC11); push_wr(32'h3000, 2'b10, 32'h0000_0011);
        push_rd(32'h0040, 2'b00, 32'h5566_7722); push_wr(32'h3004, 2'b10, 32'h0000_0022);
        push_rd(32'h0040, 2'b00, 32'hFFFF_FF33); push_wr(32'h3008, 2'b10, 32'h0000_0033);
        base = wr_cnt; dbase = dack_cnt;
        channel_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic seen;
            seen = 1'b0;
            periph_dreq = 1'b1;
            for (int c = 0; c < 50; c++) begin
                tick();
                if (rd_req) begin seen = 1'b1; break; end
            end
            if (!seen) timeout("t2_dreq_read");
            periph_dreq = 1'b0;
            wait_wr(base + i + 1);
        end
        tick();
        check("t2_dack_cnt", 32'(dack_cnt - dbase), 32'd3);
        check("t2_tcif", {31'd0, tcif_irq}, 32'd1);
        check("t2_htif", {31'd0, htif_irq}, 32'd1);
        check("t2_cnt", 32'(remaining_cnt), 32'd0);
        cleanup();

        // Circular N=2, mem word -> periph byte (truncating), clear vs set race.
        cfg(1'b1, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 16'd2, 32'h0600, 32'h0500);
        push_rd(32'h0500, 2'b10, 32'h1234_5678); push_wr(32'h0600, 2'b00, 32'h0000_0078);
        push_rd(32'h0504, 2'b10, 32'h9ABC_DEF0); push_wr(32'h0601, 2'b00, 32'h0000_00F0);
        push_rd(32'h0500, 2'b10, 32'h0BAD_F00D); push_wr(32'h0600, 2'b00, 32'h0000_000D);
        push_rd(32'h0504, 2'b10, 32'hC0FF_EE99); push_wr(32'h0601, 2'b00, 32'h0000_0099);
        base = wr_cnt;
        channel_en = 1'b1;
        wait_wreq(base + 1);
        clear_tcif = 1'b1;
        tick();
        clear_tcif = 1'b0;
        check("t3_wr_cnt", 32'(wr_cnt - base), 32'd2);
        check("t3_tcif_set_wins", {31'd0, tcif_irq}, 32'd1);
        check("t3_htif", {31'd0, htif_irq}, 32'd1);
        check("t3_reload_cnt", 32'(remaining_cnt), 32'd2);
        check("t3_reload_rd_addr", rd_addr, 32'h0500);
        check("t3_reload_wr_addr", wr_addr, 32'h0600);
        check("t3_still_busy", {31'd0, busy}, 32'd1);
        wait_wreq(base + 3);
        channel_en = 1'b0;
        tick();
        check("t3_stop_wr_cnt", 32'(wr_cnt - base), 32'd4);
        check("t3_stop_idle", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("t3_stop_no_rd", {31'd0, rd_req}, 32'd0);
        cleanup();

        // Read error on item 2 of 5, then restart with N=1.
        cfg(1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 16'd5, 32'h0200, 32'h0100);
        tci_irq_en = 0; hti_irq_en = 0; tei_irq_en = 1;
        push_rd(32'h0100, 2'b10, 32'hDEAD_BEEF); push_wr(32'h0200, 2'b10, 32'hDEAD_BEEF);
        push_rd(32'h0104, 2'b10, 32'h0000_0000);
        base = wr_cnt;
        rd_err_at = rd_cnt + 1;
        channel_en = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 100; c++) begin
                tick();
                if (teif_irq) begin seen = 1'b1; break; end
            end
            if (!seen) timeout("t4_teif");
        end
        rd_err_at = -1;
        check("t4_teif", {31'd0, teif_irq}, 32'd1);
        check("t4_tcif", {31'd0, tcif_irq}, 32'd0);
        check("t4_irq", {31'd0, irq}, 32'd1);
        check("t4_cnt", 32'(remaining_cnt), 32'd4);
        check("t4_halt", {31'd0, busy}, 32'd0);
        check("t4_wr_cnt", 32'(wr_cnt - base), 32'd1);
        cleanup();
        cfg(1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 16'd1, 32'h0800, 32'h0700);
        push_rd(32'h0700, 2'b10, 32'h5A5A_5A5A); push_wr(32'h0800, 2'b10, 32'h5A5A_5A5A);
        base = wr_cnt;
        channel_en = 1'b1;
        wait_wr(base + 1);
        check("t4r_tcif", {31'd0, tcif_irq}, 32'd1);
        check("t4r_htif_n1", {31'd0, htif_irq}, 32'd0);
        check("t4r_teif", {31'd0, teif_irq}, 32'd0);
        check("t4r_idle", {31'd0, busy}, 32'd0);
        cleanup();

        // channel_en dropped while a write is held pending.
        cfg(1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 16'd3, 32'h8000, 32'h9000);
        push_rd(32'h8000, 2'b10, 32'h0102_0304); push_wr(32'h9000, 2'b10, 32'h0102_0304);
        base = wr_cnt;
        wr_hold = 1'b1;
        channel_en = 1'b1;
        wait_wreq(base);
        channel_en = 1'b0;
        repeat (3) tick();
        check("t5_wr_held", {31'd0, wr_req}, 32'd1);
        check("t5_busy_held", {31'd0, busy}, 32'd1);
        wr_hold = 1'b0;
        wait_wr(base + 1);
        check("t5_cnt_once", 32'(remaining_cnt), 32'd2);
        check("t5_idle", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("t5_no_rd", {31'd0, rd_req}, 32'd0);
        cleanup();

        // Bad starts: zero count and reserved size.
        cfg(1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 16'd0, 32'h0, 32'h0);
        channel_en = 1'b1;
        repeat (4) tick();
        check("t6_n0_teif", {31'd0, teif_irq}, 32'd1);
        check("t6_n0_busy", {31'd0, busy}, 32'd0);
        check("t6_n0_rd", {31'd0, rd_req}, 32'd0);
        cleanup();
        cfg(1'b0, 1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b0, 16'd2, 32'h10, 32'h20);
        channel_en = 1'b1;
        repeat (4) tick();
        check("t6_rsvd_teif", {31'd0, teif_irq}, 32'd1);
        check("t6_rsvd_busy", {31'd0, busy}, 32'd0);
        check("t6_rsvd_cnt", 32'(remaining_cnt), 32'd2);
        cleanup();

        check("end_rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
        check("end_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
